gray_tracker: RTL and testbench
===============================

# gray_tracker

Downstream monitor for the 3-bit Gray-code counter. It samples the counter's `Output` and `Overflow` every clock and decodes the Gray value to binary. It extends the position with a wrap count and pulses on every legal advance and wrap. Any illegal transition, or disagreement between observed wraps and the counter's sticky overflow flag, sets a sticky fault that freezes the block until reset.

## Interface

- `WRAP_W`, default 8: width of the wrap counter; position output is `WRAP_W+3` bits.
- `Clk`, input, 1: single clock; all state updates on the rising edge.
- `Reset`, input, 1: reset; synchronous, active-high.
- `Gray`, input, 3: Gray-coded value from the counter's `Output`.
- `Overflow`, input, 1: sticky overflow flag from the counter.
- `Bin`, output, 3: registered binary decode of the last accepted `Gray`.
- `Wraps`, output, `WRAP_W`: number of 100→000 wraps accepted, modulo 2^`WRAP_W`.
- `Pos`, output, `WRAP_W+3`: `{Wraps, Bin}`.
- `Step`, output, 1: one-cycle pulse when a legal advance is accepted, wraps included.
- `Wrap`, output, 1: one-cycle pulse when a 100→000 advance is accepted.
- `Err`, output, 1: sticky fault flag.
- `ErrCode`, output, 2: 00 none, 01 illegal Gray transition, 10 overflow mismatch; latched with `Err`.

## Operation

- Decode rule: `b2=g2`, `b1=g2^g1`, `b0=b1^g0`.
- Legal successor rule: `bin(new) == bin(prev)+1 mod 8`. The sequence is 000,001,011,010,110,111,101,100,000.
- State machine has three states: SYNC, TRACK and FAULT. Internal registers are `prev[2:0]` and `ovf_prev`.
- SYNC is entered on reset. On the first non-reset edge:
  - `prev<=Gray`, `Bin<=decode(Gray)`, `ovf_prev<=Overflow`.
  - No checks are made and no pulses are produced.
  - Next state is TRACK.
- TRACK, per edge:
  - `Gray==prev`: hold all outputs; `Step` and `Wrap` are 0. `Overflow` must equal `ovf_prev`, otherwise fault 10.
  - `Gray` is the legal successor, not a wrap: update `prev` and `Bin`; `Step=1`. `Overflow` must equal `ovf_prev`, otherwise fault 10.
  - `Gray` is the legal successor and a wrap (`prev==100`, `Gray==000`): `Step=1`, `Wrap=1`, `Wraps<=Wraps+1` (modulo). `Overflow` must be 1 on the same sample, otherwise fault 10.
  - `Gray` differs from `prev` and is not the legal successor (skip, reversal or multi-bit change): fault 01.
  - If both faults apply on one edge, the code is 01.
- On a fault:
  - `Err<=1`, `ErrCode<=code`, next state FAULT.
  - `prev`, `Bin` and `Wraps` are not updated on the faulting edge.
  - `Step` and `Wrap` are 0.
- FAULT: all outputs frozen and `Step`/`Wrap` held at 0, regardless of inputs. Exit only via `Reset`.
- `ovf_prev<=Overflow` on every non-fault edge in TRACK.

## Timing

- Every output is registered.
- Reset value of every output is 0: `Bin=0`, `Wraps=0`, `Pos=0`, `Step=0`, `Wrap=0`, `Err=0`, `ErrCode=00`. State returns to SYNC.
- Reset has priority over all other conditions, including reset asserted mid-FAULT and on the same edge as a wrap.
- Latency is one cycle: a counter change at edge k appears on `Bin`/`Step` after edge k+1.
- `Step`/`Wrap` are high for exactly one cycle per accepted advance. Back-to-back advances on consecutive edges give `Step` high on consecutive cycles.
- `Wraps` rollover: from 2^`WRAP_W`-1 to 0 on the next wrap, with `Wrap=1` and no error.
- The counter and tracker share `Clk` and `Reset`. After a common reset the counter shows 000 with `Overflow=0`; the tracker captures that in SYNC.

## Test plan

- Reset, then counter enabled for 8 edges. `Bin` goes 0..7 then 0 with one cycle of lag; `Step` is high 8 cycles; `Wrap` is high once, coincident with `Bin` returning to 0. `Wraps=1`, `Pos=0x008` (`WRAP_W=8`), `Err=0`.
- `En` toggled irregularly for 20 advances. `Step` count equals 20, `Pos=20`, `Wraps=2`, and `Step` never pulses during holds.
- Force `Gray` from 001 to 010 (a skip). `Err=1` and `ErrCode=01` after the next edge; `Bin` stays at 1. Further legal inputs leave all outputs frozen until `Reset`.
- Force `Overflow` high while `Gray` holds at 011. Fault with `ErrCode=10`. Separately, force a 100→000 wrap with `Overflow` held at 0: `ErrCode=10`, `Wraps` unchanged.
- With `WRAP_W=2`, run 32 advances. `Wraps` goes 1,2,3,0 with `Wrap` pulses each time, and `Err` stays 0.
- Assert `Reset` on the same edge as a wrap, and again while in FAULT. All outputs read 0 the following cycle; the first post-reset sample is taken in SYNC without a check.

Source files
------------

// File: rtl/gray_tracker.sv
// gray_tracker: downstream monitor for a 3-bit Gray-code counter.
// Decodes, extends with a wrap count, pulses on advances, latches faults.
module gray_tracker #(
  parameter int WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [2:0]        Gray,
  input  logic              Overflow,
  output logic [2:0]        Bin,
  output logic [WRAP_W-1:0] Wraps,
  output logic [WRAP_W+2:0] Pos,
  output logic              Step,
  output logic              Wrap,
  output logic              Err,
  output logic [1:0]        ErrCode
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_ILL  = 2'b01;
  localparam logic [1:0] CODE_OVF  = 2'b10;

  function automatic logic [2:0] f_decode(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  // Architectural state
  state_t            r_state;
  logic [2:0]        r_prev;
  logic              r_ovf_prev;
  logic [2:0]        r_bin;
  logic [WRAP_W-1:0] r_wraps;
  logic              r_step;
  logic              r_wrap;
  logic              r_err;
  logic [1:0]        r_code;

  // Next-state values
  state_t            w_state_nx;
  logic [2:0]        w_prev_nx;
  logic              w_ovf_nx;
  logic [2:0]        w_bin_nx;
  logic [WRAP_W-1:0] w_wraps_nx;
  logic              w_step_nx;
  logic              w_wrap_nx;
  logic              w_err_nx;
  logic [1:0]        w_code_nx;

  // Transition classification
  logic [2:0] w_dec;
  logic [2:0] w_prev_bin;
  logic [2:0] w_succ_bin;
  logic       w_same;
  logic       w_succ;
  logic       w_is_wrap;
  logic       w_illegal;
  logic       w_ovf_bad;

  // Classify the sampled Gray value against the last accepted one
  always_comb begin
    w_dec      = f_decode(Gray);
    w_prev_bin = f_decode(r_prev);
    w_succ_bin = w_prev_bin + 3'd1;
    w_same     = (Gray == r_prev);
    w_succ     = (w_dec == w_succ_bin);
    w_is_wrap  = w_succ && (r_prev == 3'b100);
    w_illegal  = !w_same && !w_succ;
    // A wrap must coincide with the sticky flag; otherwise it must not move
    if (w_is_wrap) begin
      w_ovf_bad = !Overflow;
    end else begin
      w_ovf_bad = (Overflow != r_ovf_prev);
    end
  end

  // Next-state and next-output logic for the tracker FSM
  always_comb begin
    w_state_nx = r_state;
    w_prev_nx  = r_prev;
    w_ovf_nx   = r_ovf_prev;
    w_bin_nx   = r_bin;
    w_wraps_nx = r_wraps;
    w_step_nx  = 1'b0;
    w_wrap_nx  = 1'b0;
    w_err_nx   = r_err;
    w_code_nx  = r_code;
    unique case (r_state)
      SYNC: begin
        w_prev_nx  = Gray;
        w_bin_nx   = w_dec;
        w_ovf_nx   = Overflow;
        w_state_nx = TRACK;
      end
      TRACK: begin
        if (w_illegal) begin
          w_err_nx   = 1'b1;
          w_code_nx  = CODE_ILL;
          w_state_nx = FAULT;
        end else if (w_ovf_bad) begin
          w_err_nx   = 1'b1;
          w_code_nx  = CODE_OVF;
          w_state_nx = FAULT;
        end else begin
          w_ovf_nx = Overflow;
          if (!w_same) begin
            w_prev_nx = Gray;
            w_bin_nx  = w_dec;
            w_step_nx = 1'b1;
            if (w_is_wrap) begin
              w_wrap_nx  = 1'b1;
              w_wraps_nx = r_wraps + 1'b1;
            end
          end
        end
      end
      FAULT: begin
        w_state_nx = FAULT;
      end
      default: begin
        w_state_nx = SYNC;
        w_code_nx  = CODE_NONE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= SYNC;
      r_prev     <= 3'b000;
      r_ovf_prev <= 1'b0;
      r_bin      <= 3'b000;
      r_wraps    <= '0;
      r_step     <= 1'b0;
      r_wrap     <= 1'b0;
      r_err      <= 1'b0;
      r_code     <= CODE_NONE;
    end else begin
      r_state    <= w_state_nx;
      r_prev     <= w_prev_nx;
      r_ovf_prev <= w_ovf_nx;
      r_bin      <= w_bin_nx;
      r_wraps    <= w_wraps_nx;
      r_step     <= w_step_nx;
      r_wrap     <= w_wrap_nx;
      r_err      <= w_err_nx;
      r_code     <= w_code_nx;
    end
  end

  assign Bin     = r_bin;
  assign Wraps   = r_wraps;
  assign Pos     = {r_wraps, r_bin};
  assign Step    = r_step;
  assign Wrap    = r_wrap;
  assign Err     = r_err;
  assign ErrCode = r_code;

endmodule

// File: tb/tb_gray_tracker.sv
// tb_gray_tracker: directed checks for gray_tracker.
// Two instances: default WRAP_W=8 and WRAP_W=2 for rollover.
module tb_gray_tracker;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        rst_a = 1'b1;
  logic [2:0]  gray_a = 3'b000;
  logic        ovf_a = 1'b0;
  logic [2:0]  bin_a;
  logic [7:0]  wraps_a;
  logic [10:0] pos_a;
  logic        step_a, wrap_a, err_a;
  logic [1:0]  code_a;

  logic        rst_b = 1'b1;
  logic [2:0]  gray_b = 3'b000;
  logic        ovf_b = 1'b0;
  logic [2:0]  bin_b;
  logic [1:0]  wraps_b;
  logic [4:0]  pos_b;
  logic        step_b, wrap_b, err_b;
  logic [1:0]  code_b;

  gray_tracker #(.WRAP_W(8)) u_a (
    .Clk(Clk), .Reset(rst_a), .Gray(gray_a), .Overflow(ovf_a),
    .Bin(bin_a), .Wraps(wraps_a), .Pos(pos_a), .Step(step_a),
    .Wrap(wrap_a), .Err(err_a), .ErrCode(code_a)
  );

  gray_tracker #(.WRAP_W(2)) u_b (
    .Clk(Clk), .Reset(rst_b), .Gray(gray_b), .Overflow(ovf_b),
    .Bin(bin_b), .Wraps(wraps_b), .Pos(pos_b), .Step(step_b),
    .Wrap(wrap_b), .Err(err_b), .ErrCode(code_b)
  );

  int checks = 0;
  int failures = 0;
  int pa = 0;
  int pb = 0;
  int stepcnt = 0;
  int adv = 0;
  int idx = 0;
  logic [31:0] pat = 32'b1101_1001_1110_1011_0111_0110_1101_1011;

  function automatic logic [2:0] gfn(input int b);
    logic [2:0] v;
    v = b[2:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_bin"}, 32'(bin_a), 0);
    chk({tag, "_wraps"}, 32'(wraps_a), 0);
    chk({tag, "_pos"}, 32'(pos_a), 0);
    chk({tag, "_step"}, 32'(step_a), 0);
    chk({tag, "_wrap"}, 32'(wrap_a), 0);
    chk({tag, "_err"}, 32'(err_a), 0);
    chk({tag, "_code"}, 32'(code_a), 0);
  endtask

  task automatic a_start;
    rst_a = 1'b1;
    gray_a = 3'b000;
    ovf_a = 1'b0;
    tick;
    rst_a = 1'b0;
    tick;
    pa = 0;
  endtask

  task automatic a_adv(input int n);
    for (int i = 0; i < n; i++) begin
      pa++;
      gray_a = gfn(pa);
      if (pa % 8 == 0) ovf_a = 1'b1;
      tick;
      chk("adv_bin", 32'(bin_a), 32'(pa % 8));
      chk("adv_step", 32'(step_a), 1);
      chk("adv_wrap", 32'(wrap_a), 32'(pa % 8 == 0));
      chk("adv_err", 32'(err_a), 0);
    end
  endtask

  initial begin
    // reset state
    tick;
    chk_a_zero("reset");
    rst_a = 1'b0;
    tick;
    chk("sync_step", 32'(step_a), 0);
    chk("sync_bin", 32'(bin_a), 0);

    // eight consecutive advances incl. one wrap
    pa = 0;
    a_adv(8);
    chk("run8_wraps", 32'(wraps_a), 1);
    chk("run8_pos", 32'(pos_a), 32'h008);
    chk("run8_err", 32'(err_a), 0);

    // irregular enable, 20 advances from reset
    a_start;
    stepcnt = 0;
    adv = 0;
    idx = 0;
    while (adv < 20 && idx < 64) begin
      if (pat[idx % 32]) begin
        adv++;
        pa++;
        gray_a = gfn(pa);
        if (pa % 8 == 0) ovf_a = 1'b1;
        tick;
        stepcnt += int'(step_a);
        chk("irr_bin", 32'(bin_a), 32'(pa % 8));
      end else begin
        tick;
        stepcnt += int'(step_a);
        chk("irr_hold_step", 32'(step_a), 0);
      end
      idx++;
    end
    chk("irr_stepcnt", 32'(stepcnt), 20);
    chk("irr_pos", 32'(pos_a), 20);
    chk("irr_wraps", 32'(wraps_a), 2);
    chk("irr_err", 32'(err_a), 0);

    // skip 001 -> 010
    a_start;
    a_adv(1);
    gray_a = 3'b010;
    tick;
    chk("skip_err", 32'(err_a), 1);
    chk("skip_code", 32'(code_a), 1);
    chk("skip_bin", 32'(bin_a), 1);
    chk("skip_step", 32'(step_a), 0);
    gray_a = 3'b011;
    tick;
    chk("frz1_bin", 32'(bin_a), 1);
    chk("frz1_step", 32'(step_a), 0);
    gray_a = 3'b010;
    tick;
    chk("frz2_bin", 32'(bin_a), 1);
    chk("frz2_code", 32'(code_a), 1);
    gray_a = 3'b110;
    ovf_a = 1'b1;
    tick;
    chk("frz3_bin", 32'(bin_a), 1);
    chk("frz3_err", 32'(err_a), 1);
    chk("frz3_code", 32'(code_a), 1);
    chk("frz3_wraps", 32'(wraps_a), 0);
    // reset while in FAULT
    rst_a = 1'b1;
    tick;
    chk_a_zero("rstflt");

    // overflow rises during a hold at 011
    a_start;
    a_adv(2);
    ovf_a = 1'b1;
    tick;
    chk("ovfh_err", 32'(err_a), 1);
    chk("ovfh_code", 32'(code_a), 2);
    chk("ovfh_bin", 32'(bin_a), 2);
    chk("ovfh_step", 32'(step_a), 0);

    // wrap with overflow low
    a_start;
    a_adv(7);
    gray_a = 3'b000;
    ovf_a = 1'b0;
    tick;
    chk("ovfw_code", 32'(code_a), 2);
    chk("ovfw_wraps", 32'(wraps_a), 0);
    chk("ovfw_bin", 32'(bin_a), 7);
    chk("ovfw_wrap", 32'(wrap_a), 0);
    chk("ovfw_step", 32'(step_a), 0);

    // illegal plus overflow mismatch: illegal wins
    a_start;
    a_adv(1);
    gray_a = 3'b110;
    ovf_a = 1'b1;
    tick;
    chk("both_code", 32'(code_a), 1);

    // reset coincident with a wrap
    a_start;
    a_adv(7);
    gray_a = 3'b000;
    ovf_a = 1'b1;
    rst_a = 1'b1;
    tick;
    chk_a_zero("rstwrap");
    rst_a = 1'b0;
    gray_a = 3'b110;
    tick;
    chk("resync_bin", 32'(bin_a), 4);
    chk("resync_step", 32'(step_a), 0);
    chk("resync_err", 32'(err_a), 0);
    gray_a = 3'b111;
    tick;
    chk("resync_adv_bin", 32'(bin_a), 5);
    chk("resync_adv_step", 32'(step_a), 1);
    chk("resync_adv_err", 32'(err_a), 0);

    // WRAP_W=2 rollover over 32 advances
    rst_b = 1'b1;
    tick;
    chk("b_reset_pos", 32'(pos_b), 0);
    chk("b_reset_err", 32'(err_b), 0);
    rst_b = 1'b0;
    tick;
    pb = 0;
    for (int i = 0; i < 32; i++) begin
      pb++;
      gray_b = gfn(pb);
      if (pb % 8 == 0) ovf_b = 1'b1;
      tick;
      chk("b_bin", 32'(bin_b), 32'(pb % 8));
      chk("b_step", 32'(step_b), 1);
      chk("b_wrap", 32'(wrap_b), 32'(pb % 8 == 0));
      chk("b_wraps", 32'(wraps_b), 32'((pb / 8) % 4));
      chk("b_err", 32'(err_b), 0);
    end
    chk("b_code", 32'(code_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
